// File: rtl/spi_master_nss.sv
// SPI master with configurable word width, N active-low selects, all four CPOL/CPHA modes
// and MSB/LSB-first order; configuration is captured when START is accepted.
module spi_master_nss #(
    parameter int DW   = 8,
    parameter int NSS  = 4,
    parameter int DIVW = 4,
    parameter int SELW = 2
) (
    input  logic            clock,
    input  logic            rst,
    input  logic            start,
    input  logic [DW-1:0]   tx_data,
    input  logic [SELW-1:0] ss_sel,
    input  logic [DIVW-1:0] clk_div,
    input  logic            c_pol,
    input  logic            c_ph,
    input  logic            lsb_first,
    input  logic            miso,
    output logic            sck,
    output logic            mosi,
    output logic [NSS-1:0]  ss_n,
    output logic            busy,
    output logic            done,
    output logic [DW-1:0]   rx_data,
    output logic [1:0]      state_dbg
);

    // Handshake: START is accepted on any clock edge where the FSM is IDLE (BUSY=0),
    // including the DONE cycle; START seen while BUSY=1 is dropped, never queued.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int ECW = $clog2(2 * DW + 1);
    localparam logic [ECW-1:0] LAST_EDGE = ECW'(2 * DW);

    state_t          state;
    state_t          state_next;
    logic [DIVW-1:0] div_q;
    logic [DIVW-1:0] div_cnt;
    logic [ECW-1:0]  edge_cnt;
    logic [ECW-1:0]  edge_next;
    logic            cpha_q;
    logic            lsb_q;
    logic [DW-1:0]   tx_sr;
    logic [DW-1:0]   rx_sr;
    logic [DW-1:0]   tx_shifted;
    logic [NSS-1:0]  ss_dec;
    logic            tick;
    logic            accept;
    logic            edge_fire;
    logic            edge_lead;
    logic            do_sample;
    logic            do_update;
    logic            finish;

    assign state_dbg = state;

    // An out-of-range index matches no select, so every SS_N line stays high.
    always_comb begin
        ss_dec = '1;
        for (int i = 0; i < NSS; i++) begin
            if (ss_sel == SELW'(i)) ss_dec[i] = 1'b0;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        edge_fire  = 1'b0;
        finish     = 1'b0;
        tick       = (div_cnt == div_q);
        edge_next  = edge_cnt + 1'b1;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    edge_fire  = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                // After the last edge one more half-period elapses before HOLD.
                if (tick) begin
                    if (edge_cnt == LAST_EDGE) state_next = HOLD;
                    else edge_fire = 1'b1;
                end
            end
            HOLD: begin
                if (tick) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        edge_lead  = edge_next[0];
        do_sample  = edge_fire && (cpha_q ? !edge_lead : edge_lead);
        do_update  = edge_fire && (cpha_q ? (edge_lead && (edge_next != ECW'(1)))
                                          : (!edge_lead && (edge_next != LAST_EDGE)));
        tx_shifted = lsb_q ? (tx_sr >> 1) : (tx_sr << 1);
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            sck      <= 1'b0;
            mosi     <= 1'b0;
            ss_n     <= '1;
            busy     <= 1'b0;
            done     <= 1'b0;
            rx_data  <= '0;
            div_q    <= '0;
            div_cnt  <= '0;
            edge_cnt <= '0;
            cpha_q   <= 1'b0;
            lsb_q    <= 1'b0;
            tx_sr    <= '0;
            rx_sr    <= '0;
        end else begin
            done <= 1'b0;
            if (state != IDLE) div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (state == IDLE) sck <= c_pol;
            if (accept) begin
                div_q    <= clk_div;
                cpha_q   <= c_ph;
                lsb_q    <= lsb_first;
                tx_sr    <= tx_data;
                rx_sr    <= '0;
                ss_n     <= ss_dec;
                busy     <= 1'b1;
                div_cnt  <= '0;
                edge_cnt <= '0;
                mosi     <= lsb_first ? tx_data[0] : tx_data[DW-1];
            end
            if (edge_fire) begin
                sck      <= ~sck;
                edge_cnt <= edge_next;
            end
            if (do_sample) begin
                rx_sr <= lsb_q ? {miso, rx_sr[DW-1:1]} : {rx_sr[DW-2:0], miso};
            end
            if (do_update) begin
                tx_sr <= tx_shifted;
                mosi  <= lsb_q ? tx_shifted[0] : tx_shifted[DW-1];
            end
            if (finish) begin
                ss_n    <= '1;
                busy    <= 1'b0;
                done    <= 1'b1;
                rx_data <= rx_sr;
            end
        end
    end

endmodule

// File: tb/tb_spi_master_nss.sv
// Directed bench for spi_master_nss: loopback and slave-model transfers in all modes,
// timing, bit order, handshake corner cases and the out-of-range select.
module tb_spi_master_nss;

    logic       clock;
    logic       rst;
    logic       start;
    logic [7:0] tx_data;
    logic [1:0] ss_sel;
    logic [3:0] clk_div;
    logic       c_pol;
    logic       c_ph;
    logic       lsb_first;
    logic       miso;
    logic       sck;
    logic       mosi;
    logic [3:0] ss_n;
    logic       busy;
    logic       done;
    logic [7:0] rx_data;
    logic [1:0] state_dbg;
    logic       sck3;
    logic       mosi3;
    logic [2:0] ss_n3;
    logic       busy3;
    logic       done3;
    logic [7:0] rx_data3;
    logic [1:0] state_dbg3;

    int n_total;
    int n_bad;

    // slave model: shifts s_word out on the edge opposite to the master's sampling edge
    logic       loopback;
    logic [7:0] s_word;
    logic       s_lsb;
    logic       s_cpha;
    int         s_n;
    int         s_idx;
    logic [2:0] s_bit;
    logic       s_miso;
    logic       ss_all_high;

    int         r_fall;
    int         r_done;
    int         r_lead;
    int         r_first_lead;
    int         r_period;
    logic [7:0] r_mosi;
    logic [7:0] r_rx;
    logic [7:0] r_rx3;
    logic [3:0] r_ss_low;
    logic       r_idle_sck;
    logic       r_end_sck;
    logic       r_busy_done;
    logic       r_busy_after;
    logic       r_ss3_ok;
    logic       r_done3_seen;

    spi_master_nss #(.DW(8), .NSS(4), .DIVW(4), .SELW(2)) u_dut (
        .clock(clock), .rst(rst), .start(start), .tx_data(tx_data), .ss_sel(ss_sel),
        .clk_div(clk_div), .c_pol(c_pol), .c_ph(c_ph), .lsb_first(lsb_first), .miso(miso),
        .sck(sck), .mosi(mosi), .ss_n(ss_n), .busy(busy), .done(done), .rx_data(rx_data),
        .state_dbg(state_dbg)
    );

    spi_master_nss #(.DW(8), .NSS(3), .DIVW(4), .SELW(2)) u_dut3 (
        .clock(clock), .rst(rst), .start(start), .tx_data(tx_data), .ss_sel(ss_sel),
        .clk_div(clk_div), .c_pol(c_pol), .c_ph(c_ph), .lsb_first(lsb_first), .miso(miso),
        .sck(sck3), .mosi(mosi3), .ss_n(ss_n3), .busy(busy3), .done(done3), .rx_data(rx_data3),
        .state_dbg(state_dbg3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign ss_all_high = &ss_n;
    always @(negedge ss_all_high) s_n = 0;
    always @(sck) if (!ss_all_high) s_n = s_n + 1;

    always_comb begin
        s_idx = s_cpha ? ((s_n > 0) ? (s_n - 1) / 2 : 0) : s_n / 2;
        if (s_idx > 7) s_idx = 7;
        s_bit = s_lsb ? 3'(s_idx) : 3'(7 - s_idx);
    end
    assign s_miso = s_word[s_bit];
    assign miso   = loopback ? mosi : s_miso;

    // One transfer; records timing, MOSI bits seen at leading edges and the result.
    task automatic run_word(input logic [7:0] tx, input logic [1:0] sel, input logic [3:0] div,
                            input logic cpol, input logic cpha, input logic lsb, input logic lb,
                            input logic [7:0] sword, input int pulse_at);
        int   lead_n;
        logic prev_sck;
        tx_data = tx; ss_sel = sel; clk_div = div; c_pol = cpol; c_ph = cpha; lsb_first = lsb;
        loopback = lb; s_word = sword; s_lsb = lsb; s_cpha = cpha;
        @(negedge clock);
        @(negedge clock);
        r_idle_sck = sck;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        tx_data = ~tx; ss_sel = ~sel; clk_div = ~div; c_pol = ~cpol; c_ph = ~cpha; lsb_first = ~lsb;
        r_fall = -1; r_done = -1; r_first_lead = -1; r_period = -1; r_mosi = 8'h00;
        r_ss_low = 4'hF; r_ss3_ok = 1'b1; r_done3_seen = 1'b0; r_end_sck = ~cpol; r_busy_done = 1'b1;
        r_rx = 8'hxx; r_rx3 = 8'hxx;
        lead_n = 0;
        prev_sck = sck;
        for (int c = 0; c < 2000 && r_done < 0; c++) begin
            if (c > 0) @(negedge clock);
            if (r_fall < 0 && ss_n != 4'hF) r_fall = c;
            if (ss_n != 4'hF) r_ss_low = ss_n;
            if (ss_n3 != 3'b111) r_ss3_ok = 1'b0;
            if (done3) r_done3_seen = 1'b1;
            if (sck != prev_sck && sck != cpol) begin
                if (lead_n == 0) r_first_lead = c;
                if (lead_n == 1) r_period = c - r_first_lead;
                lead_n++;
                r_mosi = {r_mosi[6:0], mosi};
            end
            prev_sck = sck;
            if (done) begin
                r_done = c; r_end_sck = sck; r_busy_done = busy; r_rx = rx_data; r_rx3 = rx_data3;
            end
            start = (c == pulse_at);
        end
        start = 1'b0;
        r_lead = lead_n;
        repeat (3) @(negedge clock);
        r_busy_after = busy;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clock);
        n_total++; if (sck !== 1'b0) begin n_bad++; $display("FAIL reset_sck: got %b want 0", sck); end
        n_total++; if (mosi !== 1'b0) begin n_bad++; $display("FAIL reset_mosi: got %b want 0", mosi); end
        n_total++; if (ss_n !== 4'hF) begin n_bad++; $display("FAIL reset_ss_n: got %h want f", ss_n); end
        n_total++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_total++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_total++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_rx: got %h want 00", rx_data); end
        n_total++; if (state_dbg !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
        rst = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_reset_mid_shift;
        logic seen;
        tx_data = 8'hE7; ss_sel = 2'd0; clk_div = 4'd3; c_pol = 1'b0; c_ph = 1'b0; lsb_first = 1'b0;
        loopback = 1'b1;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            if (sck === 1'b1 && state_dbg === 2'd2) seen = 1'b1;
            else @(negedge clock);
        end
        n_total++; if (seen !== 1'b1) begin n_bad++; $display("FAIL midrst_reach_shift: got %b want 1", seen); end
        #2 rst = 1'b0;
        #1;
        n_total++; if (ss_n !== 4'hF) begin n_bad++; $display("FAIL midrst_ss_n: got %h want f", ss_n); end
        n_total++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        n_total++; if (sck !== 1'b0) begin n_bad++; $display("FAIL midrst_sck: got %b want 0", sck); end
        n_total++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL midrst_rx: got %h want 00", rx_data); end
        repeat (2) @(negedge clock);
        rst = 1'b1;
        repeat (2) @(negedge clock);
        n_total++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL midrst_after: busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic test_mode0_loopback;
        run_word(8'hA5, 2'd2, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, -1);
        n_total++; if (r_fall !== 0) begin n_bad++; $display("FAIL m0_ss_fall: got %0d want 0", r_fall); end
        n_total++; if (r_ss_low !== 4'b1011) begin n_bad++; $display("FAIL m0_ss_n: got %b want 1011", r_ss_low); end
        n_total++; if (r_done !== 36) begin n_bad++; $display("FAIL m0_done_lat: got %0d want 36", r_done); end
        n_total++; if (r_lead !== 8) begin n_bad++; $display("FAIL m0_pulses: got %0d want 8", r_lead); end
        n_total++; if (r_first_lead !== 2) begin n_bad++; $display("FAIL m0_first_edge: got %0d want 2", r_first_lead); end
        n_total++; if (r_period !== 4) begin n_bad++; $display("FAIL m0_period: got %0d want 4", r_period); end
        n_total++; if (r_mosi !== 8'hA5) begin n_bad++; $display("FAIL m0_mosi: got %h want a5", r_mosi); end
        n_total++; if (r_rx !== 8'hA5) begin n_bad++; $display("FAIL m0_rx: got %h want a5", r_rx); end
        n_total++; if (r_busy_done !== 1'b0) begin n_bad++; $display("FAIL m0_busy_at_done: got %b want 0", r_busy_done); end
        n_total++; if (r_idle_sck !== 1'b0) begin n_bad++; $display("FAIL m0_idle_sck: got %b want 0", r_idle_sck); end
    endtask

    task automatic test_modes;
        logic [1:0] m;
        for (int i = 1; i < 4; i++) begin
            m = 2'(i);
            run_word(8'h96, 2'd0, 4'd1, m[1], m[0], 1'b0, 1'b0, 8'h3C, -1);
            n_total++; if (r_rx !== 8'h3C) begin n_bad++; $display("FAIL mode%0d_rx: got %h want 3c", i, r_rx); end
            n_total++; if (r_idle_sck !== m[1]) begin n_bad++; $display("FAIL mode%0d_idle_sck: got %b want %b", i, r_idle_sck, m[1]); end
            n_total++; if (r_end_sck !== m[1]) begin n_bad++; $display("FAIL mode%0d_end_sck: got %b want %b", i, r_end_sck, m[1]); end
            n_total++; if (r_mosi !== 8'h96) begin n_bad++; $display("FAIL mode%0d_mosi: got %h want 96", i, r_mosi); end
            n_total++; if (r_done !== 36) begin n_bad++; $display("FAIL mode%0d_done_lat: got %0d want 36", i, r_done); end
            n_total++; if (r_lead !== 8) begin n_bad++; $display("FAIL mode%0d_pulses: got %0d want 8", i, r_lead); end
        end
    endtask

    task automatic test_lsb_first;
        run_word(8'h01, 2'd1, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h80, -1);
        n_total++; if (r_mosi !== 8'h80) begin n_bad++; $display("FAIL lsb_mosi_seq: got %b want 10000000", r_mosi); end
        n_total++; if (r_rx !== 8'h80) begin n_bad++; $display("FAIL lsb_rx: got %h want 80", r_rx); end
        n_total++; if (r_ss_low !== 4'b1101) begin n_bad++; $display("FAIL lsb_ss_n: got %b want 1101", r_ss_low); end
    endtask

    task automatic test_start_ignored;
        run_word(8'h5C, 2'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 10);
        n_total++; if (r_done !== 36) begin n_bad++; $display("FAIL ign_done_lat: got %0d want 36", r_done); end
        n_total++; if (r_rx !== 8'h5C) begin n_bad++; $display("FAIL ign_rx: got %h want 5c", r_rx); end
        n_total++; if (r_busy_after !== 1'b0) begin n_bad++; $display("FAIL ign_not_queued: busy got %b want 0", r_busy_after); end
        n_total++; if (r_ss_low !== 4'b1110) begin n_bad++; $display("FAIL ign_ss_n: got %b want 1110", r_ss_low); end
    endtask

    task automatic test_back_to_back;
        int         d1;
        int         d2;
        logic [3:0] prev_ss;
        tx_data = 8'hC3; ss_sel = 2'd1; clk_div = 4'd1; c_pol = 1'b0; c_ph = 1'b0; lsb_first = 1'b0;
        loopback = 1'b1;
        repeat (2) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        tx_data = 8'h5A;
        d1 = -1;
        prev_ss = ss_n;
        for (int c = 1; c < 200 && d1 < 0; c++) begin
            @(negedge clock);
            if (done) d1 = c;
            else prev_ss = ss_n;
        end
        n_total++; if (d1 !== 36) begin n_bad++; $display("FAIL b2b_first_done: got %0d want 36", d1); end
        n_total++; if (prev_ss !== 4'b1101) begin n_bad++; $display("FAIL b2b_ss_before_done: got %b want 1101", prev_ss); end
        n_total++; if (ss_n !== 4'hF || busy !== 1'b0) begin n_bad++; $display("FAIL b2b_done_cycle: ss_n=%b busy=%b want 1111 0", ss_n, busy); end
        n_total++; if (rx_data !== 8'hC3) begin n_bad++; $display("FAIL b2b_rx1: got %h want c3", rx_data); end
        @(negedge clock);
        n_total++; if (ss_n !== 4'b1101 || busy !== 1'b1) begin n_bad++; $display("FAIL b2b_restart: ss_n=%b busy=%b want 1101 1", ss_n, busy); end
        start = 1'b0;
        d2 = -1;
        for (int c = 1; c < 200 && d2 < 0; c++) begin
            @(negedge clock);
            if (done) d2 = c;
        end
        n_total++; if (d2 !== 36) begin n_bad++; $display("FAIL b2b_second_done: got %0d want 36", d2); end
        n_total++; if (rx_data !== 8'h5A) begin n_bad++; $display("FAIL b2b_rx2: got %h want 5a", rx_data); end
        repeat (2) @(negedge clock);
    endtask

    task automatic test_clk_div_bounds;
        run_word(8'h3A, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, -1);
        n_total++; if (r_period !== 2) begin n_bad++; $display("FAIL div0_period: got %0d want 2", r_period); end
        n_total++; if (r_first_lead !== 1) begin n_bad++; $display("FAIL div0_first_edge: got %0d want 1", r_first_lead); end
        n_total++; if (r_done !== 18) begin n_bad++; $display("FAIL div0_done_lat: got %0d want 18", r_done); end
        n_total++; if (r_rx !== 8'h3A) begin n_bad++; $display("FAIL div0_rx: got %h want 3a", r_rx); end
        run_word(8'hC5, 2'd1, 4'd15, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, -1);
        n_total++; if (r_period !== 32) begin n_bad++; $display("FAIL div15_period: got %0d want 32", r_period); end
        n_total++; if (r_first_lead !== 16) begin n_bad++; $display("FAIL div15_first_edge: got %0d want 16", r_first_lead); end
        n_total++; if (r_done !== 288) begin n_bad++; $display("FAIL div15_done_lat: got %0d want 288", r_done); end
        n_total++; if (r_rx !== 8'hC5) begin n_bad++; $display("FAIL div15_rx: got %h want c5", r_rx); end
    endtask

    task automatic test_ss_sel_range;
        run_word(8'h69, 2'd3, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, -1);
        n_total++; if (r_ss_low !== 4'b0111) begin n_bad++; $display("FAIL sel3_nss4_ss_n: got %b want 0111", r_ss_low); end
        n_total++; if (r_ss3_ok !== 1'b1) begin n_bad++; $display("FAIL sel3_nss3_all_high: got %b want 1", r_ss3_ok); end
        n_total++; if (r_done3_seen !== 1'b1) begin n_bad++; $display("FAIL sel3_nss3_done: got %b want 1", r_done3_seen); end
        n_total++; if (r_rx3 !== 8'h69) begin n_bad++; $display("FAIL sel3_nss3_rx: got %h want 69", r_rx3); end
    endtask

    initial begin
        n_total = 0; n_bad = 0;
        rst = 1'b0; start = 1'b0; tx_data = 8'h00; ss_sel = 2'd0; clk_div = 4'd0;
        c_pol = 1'b0; c_ph = 1'b0; lsb_first = 1'b0; loopback = 1'b1;
        s_word = 8'h00; s_lsb = 1'b0; s_cpha = 1'b0; s_n = 0;
        test_reset();
        test_reset_mid_shift();
        test_mode0_loopback();
        test_modes();
        test_lsb_first();
        test_start_ignored();
        test_back_to_back();
        test_clk_div_bounds();
        test_ss_sel_range();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
